// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared encodings for the frame-configurable UART transmitter
package uart_tx_pkg;
    localparam int MIN_DATA_W = 5;
    typedef enum logic [2:0] {
        PAR_NONE  = 3'b000,
        PAR_EVEN  = 3'b001,
        PAR_ODD   = 3'b010,
        PAR_MARK  = 3'b011,
        PAR_SPACE = 3'b100
    } par_mode_t;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
endpackage

// File: rtl/uart_tx_frame_gen_if.sv
// uart_tx_frame_gen_if: write-side bus between the register layer and the transmitter FIFO
interface uart_tx_frame_gen_if #(
    parameter int MAX_DATA_W = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
);
    logic                  wr_en;
    logic [MAX_DATA_W-1:0] wr_data;
    logic                  wr_ready;
    logic                  wr_ovf;
    logic [LEVEL_W-1:0]    fifo_level;
    modport master (output wr_en, wr_data, input wr_ready, wr_ovf, fifo_level);
    modport slave  (input wr_en, wr_data, output wr_ready, wr_ovf, fifo_level);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: show-ahead transmit FIFO; writes while full are dropped and flagged
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int WIDTH      = 9
) (
    input  logic                        clk,
    input  logic                        aresetn,
    input  logic                        push,
    input  logic                        pop,
    input  logic [WIDTH-1:0]            din,
    output logic [WIDTH-1:0]            dout,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        ovf
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LW    = PTR_W + 1;
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wp, rp;
    logic do_push, do_pop;
    assign full    = level == LW'(FIFO_DEPTH);
    assign empty   = level == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= din;
    // Overflow is judged on the registered full flag, so a same-cycle pop does not rescue the write
    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else begin
            ovf   <= push && full;
            wp    <= do_push ? wp + 1'b1 : wp;
            rp    <= do_pop ? rp + 1'b1 : rp;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
endmodule

// File: rtl/uart_tx_frame_gen.sv
// uart_tx_frame_gen: UART transmitter with runtime frame format, break generation and a transmit FIFO
module uart_tx_frame_gen
    import uart_tx_pkg::*;
#(
    parameter int MAX_DATA_W = 9,
    parameter int FIFO_DEPTH = 16,
    parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1,
    parameter int LEN_W      = $clog2(MAX_DATA_W + 1)
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic                baud_tick,
    uart_tx_frame_gen_if.slave  wr,
    input  logic [LEN_W-1:0]    data_len,
    input  logic [2:0]          parity_mode,
    input  logic                stop_two,
    input  logic                break_en,
    output logic                tx_busy,
    output logic                tx_done,
    output logic                tx
);
    state_t                state;
    logic [MAX_DATA_W-1:0] head, shreg;
    logic [LEN_W-1:0]      cnt, len_r, len_clamped;
    logic [2:0]            mode_r;
    logic                  stop_r, stop_2nd, par, par_en, par_bit;
    logic                  full, empty, pop;
    logic [LEVEL_W-1:0]    level;

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(MAX_DATA_W)) u_fifo (
        .clk(clk), .aresetn(aresetn), .push(wr.wr_en), .pop(pop), .din(wr.wr_data),
        .dout(head), .full(full), .empty(empty), .level(level), .ovf(wr.wr_ovf)
    );

    assign wr.wr_ready   = !full;
    assign wr.fifo_level = level;
    assign tx_busy       = state != IDLE;
    assign len_clamped   = data_len < LEN_W'(MIN_DATA_W) ? LEN_W'(MIN_DATA_W) :
                           data_len > LEN_W'(MAX_DATA_W) ? LEN_W'(MAX_DATA_W) : data_len;
    assign par_en  = mode_r inside {PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE};
    assign par_bit = mode_r == PAR_EVEN ? par : mode_r == PAR_ODD ? ~par : mode_r == PAR_MARK;
    // A new frame starts from IDLE or straight out of the last stop bit, never while a break is requested
    assign pop = baud_tick && !empty && !break_en &&
                 (state == IDLE || (state == STOP && (!stop_r || stop_2nd)));

    always_ff @(posedge clk or negedge aresetn)
        if (!aresetn) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            shreg    <= '0;
            cnt      <= '0;
            len_r    <= '0;
            mode_r   <= '0;
            stop_r   <= 1'b0;
            stop_2nd <= 1'b0;
            par      <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (pop) begin
                shreg  <= head;
                len_r  <= len_clamped;
                mode_r <= parity_mode;
                stop_r <= stop_two;
            end
            if (baud_tick)
                case (state)
                    IDLE: begin
                        tx    <= ~(break_en | pop);
                        state <= break_en ? BREAK : pop ? START : IDLE;
                    end
                    START: begin
                        tx    <= shreg[0];
                        shreg <= shreg >> 1;
                        par   <= shreg[0];
                        cnt   <= LEN_W'(1);
                        state <= DATA;
                    end
                    DATA:
                        if (cnt < len_r) begin
                            tx    <= shreg[0];
                            shreg <= shreg >> 1;
                            par   <= par ^ shreg[0];
                            cnt   <= cnt + 1'b1;
                        end else begin
                            tx    <= par_en ? par_bit : 1'b1;
                            state <= par_en ? PARITY : STOP;
                        end
                    PARITY: begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                    STOP:
                        if (stop_r && !stop_2nd) stop_2nd <= 1'b1;
                        else begin
                            tx_done  <= 1'b1;
                            stop_2nd <= 1'b0;
                            tx       <= ~(pop | break_en);
                            state    <= pop ? START : break_en ? BREAK : IDLE;
                        end
                    BREAK:
                        if (!break_en) begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    default: state <= IDLE;
                endcase
        end
endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// tb_uart_tx_frame_gen: directed frame, FIFO, break and reset vectors against hand-computed tx sequences
module tb_uart_tx_frame_gen;
    logic       clk = 1'b0, aresetn = 1'b0, baud_tick = 1'b0;
    logic       stop_two = 1'b0, break_en = 1'b0;
    logic [3:0] data_len = 4'd8;
    logic [2:0] parity_mode = 3'b000;
    logic       tx_busy, tx_done, tx;
    logic [31:0] bits;
    int         dones, total_dones;
    int         n_vec = 0, n_bad = 0;
    logic [8:0] w;

    uart_tx_frame_gen_if wr_if ();

    uart_tx_frame_gen dut (
        .clk(clk), .aresetn(aresetn), .baud_tick(baud_tick), .wr(wr_if),
        .data_len(data_len), .parity_mode(parity_mode), .stop_two(stop_two),
        .break_en(break_en), .tx_busy(tx_busy), .tx_done(tx_done), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [8:0] d);
        @(negedge clk);
        wr_if.wr_en   = 1'b1;
        wr_if.wr_data = d;
        @(negedge clk);
        wr_if.wr_en   = 1'b0;
    endtask

    // bits[i] is tx right after tick i; every clock is scanned so stray tx_done pulses are counted
    task automatic run_ticks(input int n, output logic [31:0] b, output int d);
        b = '0;
        d = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            baud_tick = 1'b1;
            @(negedge clk);
            baud_tick = 1'b0;
            b[i] = tx;
            d += int'(tx_done);
            repeat (2) begin
                @(negedge clk);
                d += int'(tx_done);
            end
        end
    endtask

    function automatic logic [8:0] fill_word(input int k);
        return 9'((k * 7 + 3) % 32);
    endfunction

    initial begin
        wr_if.wr_en   = 1'b0;
        wr_if.wr_data = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_ready", 32'(wr_if.wr_ready), 32'd1);
        check("rst_level", 32'(wr_if.fifo_level), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_ovf", 32'(wr_if.wr_ovf), 32'd0);
        aresetn = 1'b1;

        // 8N1, 0x55
        write_word(9'h055);
        check("t1_level", 32'(wr_if.fifo_level), 32'd1);
        run_ticks(11, bits, dones);
        check("t1_bits", bits, 32'h6AA);
        check("t1_done", 32'(dones), 32'd1);
        check("t1_busy", 32'(tx_busy), 32'd0);

        // 7 data bits, odd parity, upper bits of 0x1FF ignored
        data_len = 4'd7;
        parity_mode = 3'b010;
        write_word(9'h1FF);
        run_ticks(11, bits, dones);
        check("t2_bits", bits, 32'h6FE);
        check("t2_done", 32'(dones), 32'd1);

        // three back-to-back 5-bit frames with two stop bits
        data_len = 4'd5;
        parity_mode = 3'b000;
        stop_two = 1'b1;
        write_word(9'h001);
        write_word(9'h01E);
        write_word(9'h00A);
        check("t3_level3", 32'(wr_if.fifo_level), 32'd3);
        run_ticks(1, bits, dones);
        check("t3_start", bits, 32'h0);
        check("t3_level2", 32'(wr_if.fifo_level), 32'd2);
        run_ticks(8, bits, dones);
        check("t3_f0", bits, 32'h61);
        check("t3_level1", 32'(wr_if.fifo_level), 32'd1);
        total_dones = dones;
        run_ticks(8, bits, dones);
        check("t3_f1", bits, 32'h7E);
        check("t3_level0", 32'(wr_if.fifo_level), 32'd0);
        total_dones += dones;
        run_ticks(8, bits, dones);
        check("t3_f2", bits, 32'hEA);
        check("t3_dones", 32'(total_dones + dones), 32'd3);
        check("t3_busy", 32'(tx_busy), 32'd0);

        // fill the FIFO, then overflow in the same cycle as a pop
        stop_two = 1'b0;
        for (int k = 0; k < 16; k++) write_word(fill_word(k));
        check("t4_level16", 32'(wr_if.fifo_level), 32'd16);
        check("t4_ready", 32'(wr_if.wr_ready), 32'd0);
        @(negedge clk);
        wr_if.wr_en   = 1'b1;
        wr_if.wr_data = 9'h155;
        baud_tick     = 1'b1;
        @(negedge clk);
        wr_if.wr_en   = 1'b0;
        baud_tick     = 1'b0;
        check("t4_ovf", 32'(wr_if.wr_ovf), 32'd1);
        check("t4_start", 32'(tx), 32'd0);
        check("t4_level15", 32'(wr_if.fifo_level), 32'd15);
        @(negedge clk);
        check("t4_ovf_clr", 32'(wr_if.wr_ovf), 32'd0);
        total_dones = 0;
        for (int k = 0; k < 16; k++) begin
            w = fill_word(k);
            run_ticks(7, bits, dones);
            total_dones += dones;
            check($sformatf("t4_frame%0d", k), bits, {25'd0, (k == 15), 1'b1, w[4:0]});
        end
        check("t4_dones", 32'(total_dones), 32'd16);
        check("t4_level_end", 32'(wr_if.fifo_level), 32'd0);

        // break requested during data bit 3 with a second word queued
        data_len = 4'd8;
        write_word(9'h00F);
        write_word(9'h033);
        run_ticks(4, bits, dones);
        check("t5_head", bits, 32'hE);
        break_en = 1'b1;
        run_ticks(7, bits, dones);
        check("t5_tail", bits, 32'h21);
        check("t5_done", 32'(dones), 32'd1);
        run_ticks(2, bits, dones);
        check("t5_break", bits, 32'h0);
        check("t5_break_busy", 32'(tx_busy), 32'd1);
        break_en = 1'b0;
        run_ticks(1, bits, dones);
        check("t5_mark", bits, 32'h1);
        check("t5_mark_busy", 32'(tx_busy), 32'd0);
        run_ticks(1, bits, dones);
        check("t5_next_start", bits, 32'h0);
        run_ticks(10, bits, dones);
        check("t5_next_frame", bits, 32'h333);
        check("t5_next_done", 32'(dones), 32'd1);

        // asynchronous reset mid-frame with words queued
        for (int k = 0; k < 5; k++) write_word(9'h0F0 + 9'(k));
        run_ticks(2, bits, dones);
        check("t6_in_frame", 32'(tx_busy), 32'd1);
        @(negedge clk);
        #2 aresetn = 1'b0;
        #1;
        check("t6_rst_tx", 32'(tx), 32'd1);
        check("t6_rst_level", 32'(wr_if.fifo_level), 32'd0);
        check("t6_rst_busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        aresetn = 1'b1;
        run_ticks(3, bits, dones);
        check("t6_quiet", bits, 32'h7);
        check("t6_quiet_busy", 32'(tx_busy), 32'd0);
        write_word(9'h000);
        run_ticks(1, bits, dones);
        check("t6_new_start", bits, 32'h0);
        run_ticks(10, bits, dones);
        check("t6_new_frame", bits, 32'h300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
